// File: rtl/trakball_emu.sv
// trakball_emu: turns digital directions and the analog stick into Centipede trackball
// clock/direction pulses, one ramped phase-accumulator channel per axis.
module trakball_axis #(
    parameter int RAMP_TICKS = 200,
    parameter int MIN_SPEED  = 8,
    parameter int MAX_SPEED  = 64,
    parameter int DEADZONE   = 16
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       tick_i,
    input  logic       pos_i,
    input  logic       neg_i,
    input  logic [7:0] ana_i,
    output logic       dir_o,
    output logic       clk_o,
    output logic [7:0] speed_o
);
    typedef enum logic [1:0] {IDLE, DIG, ANA} state_e;
    localparam int RW = $clog2(RAMP_TICKS + 1);
    localparam logic [8:0] MAX = 9'(MAX_SPEED);
    localparam logic [8:0] DZ = 9'(DEADZONE);
    localparam logic [7:0] MIN8 = 8'(MIN_SPEED);
    state_e state_q, state_d, req;
    logic [7:0] acc_q, acc_d, speed_q, speed_d, ana_spd, ramp_spd;
    logic [RW-1:0] ramp_q, ramp_d;
    logic dir_q, dir_d, clk_q, clk_d, sgn, wrap, dig;
    logic [8:0] mag, half, inc, sum;

    // 9-bit magnitude so that -128 maps to 128
    assign mag      = ana_i[7] ? 9'd0 - {1'b1, ana_i} : {1'b0, ana_i};
    assign half     = mag >> 1;
    assign inc      = {1'b0, speed_q} + 9'd1;
    assign ana_spd  = 8'(half > MAX ? MAX : half);
    assign ramp_spd = 8'(inc > MAX ? MAX : inc);
    assign wrap     = ramp_q == RW'(RAMP_TICKS - 1);
    assign dig      = pos_i ^ neg_i;
    assign sgn      = dig ? pos_i : !ana_i[7];
    assign req      = dig ? DIG : (!pos_i && !neg_i && mag > DZ) ? ANA : IDLE;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        speed_d = speed_q;
        ramp_d  = ramp_q;
        dir_d   = dir_q;
        clk_d   = clk_q;
        sum     = '0;
        if (tick_i) begin
            state_d = req;
            if (req == IDLE) begin
                speed_d = '0;
                acc_d   = '0;
            end else if (state_q == IDLE || sgn != dir_q) begin
                // entry or reversal: move dir on a tick that cannot also toggle clk
                dir_d   = sgn;
                acc_d   = '0;
                ramp_d  = '0;
                speed_d = req == DIG ? MIN8 : ana_spd;
            end else begin
                ramp_d  = (state_q == DIG && !wrap) ? ramp_q + 1'b1 : '0;
                speed_d = req == ANA ? ana_spd : state_q == ANA ? MIN8 : wrap ? ramp_spd : speed_q;
                sum     = {1'b0, acc_q} + {1'b0, speed_d};
                acc_d   = sum[7:0];
                clk_d   = clk_q ^ sum[8];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            acc_q   <= '0;
            speed_q <= '0;
            ramp_q  <= '0;
            dir_q   <= 1'b0;
            clk_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            speed_q <= speed_d;
            ramp_q  <= ramp_d;
            dir_q   <= dir_d;
            clk_q   <= clk_d;
        end
    end

    assign dir_o   = dir_q;
    assign clk_o   = clk_q;
    assign speed_o = speed_q;
endmodule

module trakball_emu #(
    parameter int TICK_DIV   = 1200,
    parameter int RAMP_TICKS = 200,
    parameter int MIN_SPEED  = 8,
    parameter int MAX_SPEED  = 64,
    parameter int DEADZONE   = 16
) (
    input  logic       clk_12mhz,
    input  logic       reset_n,
    input  logic       up,
    input  logic       down,
    input  logic       left,
    input  logic       right,
    input  logic [7:0] analog_x,
    input  logic [7:0] analog_y,
    output logic [7:0] trakball_o,
    output logic [7:0] h_speed,
    output logic [7:0] v_speed
);
    localparam int PW = $clog2(TICK_DIV + 1);
    logic [PW-1:0] presc_q;
    logic tick, h_dir, h_clk, v_dir, v_clk;

    assign tick = presc_q == PW'(TICK_DIV - 1);

    always_ff @(posedge clk_12mhz or negedge reset_n) begin
        if (!reset_n) presc_q <= '0;
        else          presc_q <= tick ? '0 : presc_q + 1'b1;
    end

    trakball_axis #(
        .RAMP_TICKS(RAMP_TICKS), .MIN_SPEED(MIN_SPEED), .MAX_SPEED(MAX_SPEED), .DEADZONE(DEADZONE)
    ) u_h (
        .clk_i(clk_12mhz), .rst_ni(reset_n), .tick_i(tick), .pos_i(right), .neg_i(left),
        .ana_i(analog_x), .dir_o(h_dir), .clk_o(h_clk), .speed_o(h_speed)
    );

    trakball_axis #(
        .RAMP_TICKS(RAMP_TICKS), .MIN_SPEED(MIN_SPEED), .MAX_SPEED(MAX_SPEED), .DEADZONE(DEADZONE)
    ) u_v (
        .clk_i(clk_12mhz), .rst_ni(reset_n), .tick_i(tick), .pos_i(down), .neg_i(up),
        .ana_i(analog_y), .dir_o(v_dir), .clk_o(v_clk), .speed_o(v_speed)
    );

    assign trakball_o = {4'b0, v_dir, v_clk, h_dir, h_clk};
endmodule
